// File: rtl/rr_arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package rr_arb_pkg;
    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request bit at or after 'start',
// wrapping 7 -> 0. Rotate right, priority-encode the lowest bit, un-rotate.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;

    always_comb begin
        // rot[k] = req[(start + k) mod 8]
        dbl   = {req, req} >> start;
        rot   = dbl[N_REQ-1:0];
        found = |rot;
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        idx = start + off;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and a
// bounded hold time so a persistent winner cannot starve the others.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    state_t            state, state_n;
    logic [IDX_W-1:0]  ptr, ptr_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [N_REQ-1:0]  gnt_n;
    logic [IDX_W-1:0]  idx_n;
    logic [IDX_W-1:0]  pick_start;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              hold_expired;
    logic              others_req;

    // Valid semantics: gnt_valid is high exactly while gnt holds one bit; the
    // owner of gnt[i] keeps it while req[i] stays high, up to MAX_HOLD cycles
    // when others are waiting. There is no ready: dropping req releases.
    assign gnt_valid = |gnt;

    rr_pick8 u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign others_req   = |(req & ~gnt);

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        hold_n     = hold_cnt;
        gnt_n      = gnt;
        idx_n      = gnt_idx;
        pick_start = (state == GRANT) ? gnt_idx + IDX_W'(1) : ptr;

        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = GRANT;
                    gnt_n   = N_REQ'(1) << pick_idx;
                    idx_n   = pick_idx;
                    ptr_n   = pick_idx + IDX_W'(1);
                    hold_n  = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_idx] || (hold_expired && others_req)) begin
                    // Release or preemption; the current winner is never the
                    // pick here since the search starts just past it.
                    if (pick_found) begin
                        gnt_n  = N_REQ'(1) << pick_idx;
                        idx_n  = pick_idx;
                        ptr_n  = pick_idx + IDX_W'(1);
                        hold_n = '0;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        idx_n   = '0;
                        hold_n  = '0;
                    end
                end else if (!hold_expired && hold_cnt != HOLD_SAT) begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            gnt_idx  <= idx_n;
        end
    end
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4): the driver queues the expected
// {gnt, gnt_idx, gnt_valid} for each cycle; the monitor pops and compares.
module tb_rr_arbiter8;
    localparam int W = 12;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    logic [W-1:0] exp_q[$];
    int tests;
    int fails;
    int cyc;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] pack_exp(input logic [7:0] g);
        logic [2:0] ix;
        ix = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) ix = 3'(i);
        end
        return {g, ix, |g};
    endfunction

    // driver: one call per cycle, inputs applied at the falling edge
    task automatic step(input logic [7:0] r, input logic rs, input logic [7:0] eg);
        rst = rs;
        req = r;
        exp_q.push_back(pack_exp(eg));
        @(negedge clk);
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {gnt, gnt_idx, gnt_valid};
                tests++;
                if (act_v !== exp_v) begin
                    fails++;
                    $display("FAIL cycle%0d grant: got gnt=%h idx=%0d valid=%b, want gnt=%h idx=%0d valid=%b",
                             cyc, act_v[11:4], act_v[3:1], act_v[0],
                             exp_v[11:4], exp_v[3:1], exp_v[0]);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        req   = 8'h00;
        @(negedge clk);

        // reset holds outputs low despite full request
        step(8'hFF, 1'b1, 8'h00);
        step(8'hFF, 1'b1, 8'h00);

        // single requester, then release to idle
        step(8'h10, 1'b0, 8'h10);
        step(8'h00, 1'b0, 8'h00);

        // full rotation, each winner drops right after its grant
        step(8'h00, 1'b1, 8'h00);
        step(8'hFF, 1'b0, 8'h01);
        for (int i = 0; i < 8; i++) begin
            step(~(8'h01 << i), 1'b0, 8'h01 << ((i + 1) % 8));
        end
        step(8'h00, 1'b0, 8'h00);

        // hold limit preempts between two persistent requesters
        step(8'h00, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) step(8'h03, 1'b0, 8'h01);
        for (int i = 0; i < 4; i++) step(8'h03, 1'b0, 8'h02);
        step(8'h03, 1'b0, 8'h01);
        step(8'h00, 1'b0, 8'h00);

        // lone requester keeps grant past the hold limit
        for (int i = 0; i < 10; i++) step(8'h08, 1'b0, 8'h08);
        // release and new request on the same edge: no bubble
        step(8'h20, 1'b0, 8'h20);
        step(8'h00, 1'b0, 8'h00);

        // mid-grant reset clears the pointer
        step(8'h40, 1'b0, 8'h40);
        step(8'h40, 1'b1, 8'h00);
        step(8'h41, 1'b0, 8'h01);
        step(8'h00, 1'b0, 8'h00);
        step(8'h40, 1'b0, 8'h40);
        step(8'h40, 1'b1, 8'h00);
        step(8'hC0, 1'b0, 8'h40);
        step(8'h00, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
